// File: rtl/core_pkg.sv
// Shared definitions for the memory arbiter.
//   DATA_W  : default data/address width in bits.
//   owner_e : which port owns the response arriving from RAM in the next cycle.
package core_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port single-RAM arbiter: an instruction-fetch port and a data port
// share one RAM that has a 1-cycle read latency. Data has priority, but
// fetch is forced through after STARVE_MAX consecutive data grants that
// happen while fetch is waiting.
// Ports:
//   clk, rst (async, active-low)
//   fetch : if_req, if_addr -> if_gnt (comb), if_valid, if_rdata
//   data  : d_req, d_we, d_addr, d_wdata -> d_gnt (comb), d_valid, d_rdata, d_err
//   RAM   : ram_en, ram_we, ram_addr, ram_di (comb) <- ram_dout (1-cycle latency)
module mem_arbiter #(
  parameter int DATA_W     = core_pkg::DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_dout
);
  import core_pkg::*;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  owner_e            r_owner;
  owner_e            w_owner_nxt;
  logic [3:0]        r_starve;
  logic [3:0]        w_starve_nxt;
  logic              r_d_rd;
  logic              r_d_err;
  logic [DATA_W-1:0] r_if_hold;
  logic [DATA_W-1:0] r_d_hold;
  logic              w_if_gnt;
  logic              w_d_gnt;
  logic              w_force_f;
  logic              w_d_align;

  // Grant selection, RAM drive and next-state for owner / starvation counter.
  always_comb begin
    w_if_gnt     = 1'b0;
    w_d_gnt      = 1'b0;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = {DATA_W{1'b0}};
    ram_di       = {DATA_W{1'b0}};
    w_owner_nxt  = OWN_NONE;
    w_starve_nxt = r_starve;
    w_d_align    = (d_addr[1:0] == 2'b00);
    w_force_f    = if_req && d_req && (r_starve == STARVE_LIM);

    // Gated by rst so grants and RAM strobes are low while reset is held.
    if (rst) begin
      if (d_req && !w_force_f) begin
        w_d_gnt = 1'b1;
      end else if (if_req) begin
        w_if_gnt = 1'b1;
      end else begin
        w_d_gnt  = 1'b0;
      end
    end else begin
      w_d_gnt  = 1'b0;
    end

    if (w_d_gnt) begin
      // A misaligned access is granted but never touches the RAM.
      ram_en      = w_d_align;
      ram_we      = w_d_align && d_we;
      ram_addr    = d_addr;
      ram_di      = d_wdata;
      w_owner_nxt = OWN_DATA;
    end else if (w_if_gnt) begin
      ram_en      = 1'b1;
      ram_addr    = if_addr;
      w_owner_nxt = OWN_FETCH;
    end else begin
      w_owner_nxt = OWN_NONE;
    end

    if (!if_req || w_if_gnt) begin
      w_starve_nxt = 4'd0;
    end else if (w_d_gnt && (r_starve != STARVE_LIM)) begin
      w_starve_nxt = r_starve + 4'd1;
    end else begin
      w_starve_nxt = r_starve;
    end
  end

  // Owner, response flags, starvation counter and held read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner   <= OWN_NONE;
      r_starve  <= 4'd0;
      r_d_rd    <= 1'b0;
      r_d_err   <= 1'b0;
      r_if_hold <= {DATA_W{1'b0}};
      r_d_hold  <= {DATA_W{1'b0}};
    end else begin
      r_owner  <= w_owner_nxt;
      r_starve <= w_starve_nxt;
      r_d_rd   <= w_d_gnt && w_d_align && !d_we;
      r_d_err  <= w_d_gnt && !w_d_align;
      if (r_owner == OWN_FETCH) begin
        r_if_hold <= ram_dout;
      end
      if ((r_owner == OWN_DATA) && r_d_rd) begin
        r_d_hold <= ram_dout;
      end
    end
  end

  assign if_gnt   = w_if_gnt;
  assign d_gnt    = w_d_gnt;
  assign if_valid = (r_owner == OWN_FETCH);
  assign d_valid  = (r_owner == OWN_DATA);
  assign d_err    = r_d_err;
  // RAM data is live in the response cycle; afterwards the held copy is shown.
  assign if_rdata = (r_owner == OWN_FETCH) ? ram_dout : r_if_hold;
  assign d_rdata  = ((r_owner == OWN_DATA) && r_d_rd) ? ram_dout : r_d_hold;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small 1-cycle-latency RAM model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_gnt, if_valid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic        d_gnt, d_valid, d_err;
  logic [31:0] d_rdata;
  logic        ram_en, ram_we;
  logic [31:0] ram_addr, ram_di;
  logic [31:0] ram_dout = 32'd0;

  logic [31:0] mem [0:1023];
  int n_total = 0;
  int n_bad   = 0;

  mem_arbiter #(.DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, read data one cycle after ram_en.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr[11:2]] <= ram_di;
      else        ram_dout <= mem[ram_addr[11:2]];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    if_req = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;
  endtask

  initial begin
    logic [5:0]  exp_d;
    logic [31:0] exp_prev;
    bit          prev_f;

    for (int k = 0; k < 1024; k++) mem[k] = 32'hC0DE0000 | 32'(k);
    mem[4] = 32'hDEADBEEF;  // byte address 0x10

    // Reset state, with a request pending to show grants are held off.
    if_req = 1'b1;
    if_addr = 32'h10;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_if_gnt",   {31'd0, if_gnt},   32'd0);
    check_val("rst_d_gnt",    {31'd0, d_gnt},    32'd0);
    check_val("rst_ram_en",   {31'd0, ram_en},   32'd0);
    check_val("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check_val("rst_d_valid",  {31'd0, d_valid},  32'd0);
    check_val("rst_d_err",    {31'd0, d_err},    32'd0);
    check_val("rst_if_rdata", if_rdata,          32'd0);
    check_val("rst_d_rdata",  d_rdata,           32'd0);

    // Fetch only, granted in the first cycle after release.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("f_if_gnt",   {31'd0, if_gnt}, 32'd1);
    check_val("f_d_gnt",    {31'd0, d_gnt},  32'd0);
    check_val("f_ram_en",   {31'd0, ram_en}, 32'd1);
    check_val("f_ram_we",   {31'd0, ram_we}, 32'd0);
    check_val("f_ram_addr", ram_addr,        32'h10);
    @(negedge clk);
    idle();
    #1;
    check_val("f_if_valid", {31'd0, if_valid}, 32'd1);
    check_val("f_if_rdata", if_rdata,          32'hDEADBEEF);
    check_val("f_d_valid",  {31'd0, d_valid},  32'd0);
    check_val("idle_ram_en",{31'd0, ram_en},   32'd0);
    @(negedge clk);
    #1;
    check_val("f_if_valid_drop", {31'd0, if_valid}, 32'd0);
    check_val("f_if_rdata_hold", if_rdata,          32'hDEADBEEF);

    // Both request, data write wins.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h14;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h5;
    #1;
    check_val("w_d_gnt",    {31'd0, d_gnt},  32'd1);
    check_val("w_if_gnt",   {31'd0, if_gnt}, 32'd0);
    check_val("w_ram_we",   {31'd0, ram_we}, 32'd1);
    check_val("w_ram_di",   ram_di,          32'h5);
    check_val("w_ram_addr", ram_addr,        32'h20);
    @(negedge clk);
    idle();
    #1;
    check_val("w_d_valid", {31'd0, d_valid}, 32'd1);
    check_val("w_d_err",   {31'd0, d_err},   32'd0);
    check_val("w_d_rdata", d_rdata,          32'd0);

    // Read back the written word.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    @(negedge clk);
    idle();
    #1;
    check_val("rb_d_valid", {31'd0, d_valid}, 32'd1);
    check_val("rb_d_rdata", d_rdata,          32'h5);

    // Starvation: both held six cycles -> D,D,D,D,F,D.
    exp_d = 6'b101111;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i < 6) begin
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
      end else begin
        idle();
      end
      #1;
      if (i < 6) begin
        check_val($sformatf("st_d_gnt%0d", i),  {31'd0, d_gnt},  {31'd0, exp_d[i]});
        check_val($sformatf("st_if_gnt%0d", i), {31'd0, if_gnt}, {31'd0, ~exp_d[i]});
      end
      if (i > 0) begin
        check_val($sformatf("st_d_valid%0d", i),  {31'd0, d_valid},  {31'd0, exp_d[i-1]});
        check_val($sformatf("st_if_valid%0d", i), {31'd0, if_valid}, {31'd0, ~exp_d[i-1]});
        if (exp_d[i-1]) check_val($sformatf("st_d_rdata%0d", i), d_rdata, 32'h5);
        else            check_val($sformatf("st_if_rdata%0d", i), if_rdata, 32'hDEADBEEF);
      end
    end

    // Misaligned data read: no RAM access, error response, rdata unchanged.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h22;
    #1;
    check_val("mis_d_gnt",  {31'd0, d_gnt},  32'd1);
    check_val("mis_ram_en", {31'd0, ram_en}, 32'd0);
    @(negedge clk);
    idle();
    #1;
    check_val("mis_d_valid", {31'd0, d_valid}, 32'd1);
    check_val("mis_d_err",   {31'd0, d_err},   32'd1);
    check_val("mis_d_rdata", d_rdata,          32'h5);
    @(negedge clk);
    #1;
    check_val("mis_d_err_drop", {31'd0, d_err}, 32'd0);

    // Alternating fetch / data reads every cycle.
    prev_f = 1'b0;
    exp_prev = 32'd0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      idle();
      if (i < 8) begin
        if (i % 2 == 0) begin
          if_req = 1'b1; if_addr = 32'h100 + 32'(4 * i);
        end else begin
          d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200 + 32'(4 * i);
        end
      end
      #1;
      if (i < 8) begin
        check_val($sformatf("alt_gnt%0d", i), {30'd0, if_gnt, d_gnt},
                  (i % 2 == 0) ? 32'd2 : 32'd1);
      end
      if (i > 0) begin
        check_val($sformatf("alt_valid%0d", i), {30'd0, if_valid, d_valid},
                  prev_f ? 32'd2 : 32'd1);
        if (prev_f) check_val($sformatf("alt_if_rdata%0d", i), if_rdata, exp_prev);
        else        check_val($sformatf("alt_d_rdata%0d", i),  d_rdata,  exp_prev);
      end
      prev_f = (i % 2 == 0);
      exp_prev = prev_f ? (32'hC0DE0000 | 32'((32'h100 + 32'(4 * i)) >> 2))
                        : (32'hC0DE0000 | 32'((32'h200 + 32'(4 * i)) >> 2));
    end

    // Reset asserted right after a fetch grant discards the response.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    check_val("rr_if_gnt", {31'd0, if_gnt}, 32'd1);
    rst = 1'b0;
    idle();
    #1;
    check_val("rr_if_gnt_rst", {31'd0, if_gnt},   32'd0);
    check_val("rr_ram_en_rst", {31'd0, ram_en},   32'd0);
    check_val("rr_if_rdata",   if_rdata,          32'd0);
    check_val("rr_d_rdata",    d_rdata,           32'd0);
    @(negedge clk);
    #1;
    check_val("rr_if_valid_in", {31'd0, if_valid}, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check_val($sformatf("rr_if_valid_after%0d", i), {31'd0, if_valid}, 32'd0);
      check_val($sformatf("rr_d_valid_after%0d", i),  {31'd0, d_valid},  32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
